// File: rtl/prog_pkg.sv
// Shared definitions for the program-memory loader and its RAM.
package prog_pkg;

   localparam int unsigned PROG_ADRS_W = 9;
   localparam int unsigned PROG_DATA_W = 12;
   localparam logic [7:0]  LOAD_HDR    = 8'hA5;

   typedef enum logic [3:0] {
      IDLE,
      HDR,
      CNT_HI,
      CNT_LO,
      W_HI,
      W_LO,
      CHK,
      DONE,
      ERR
   } load_state_t;

endpackage

// File: rtl/prog_ram.sv
// Program RAM: write port fed by the loader, registered read port matching the CPU's program memory.
module prog_ram
   import prog_pkg::*;
#(
   parameter int unsigned ADRS_W = PROG_ADRS_W,
   parameter int unsigned DATA_W = PROG_DATA_W
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADRS_W-1:0] wr_adrs,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADRS_W-1:0] rd_adrs,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADRS_W];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_adrs] <= wr_data;
      rd_data <= mem[rd_adrs];
   end

endmodule

// File: rtl/prog_loader.sv
// Frame receiver that unpacks byte pairs into 12-bit words and writes them into program RAM,
// holding the CPU while a load is in progress.
module prog_loader
   import prog_pkg::*;
#(
   parameter int unsigned ADRS_W      = PROG_ADRS_W,
   parameter int unsigned DATA_W      = PROG_DATA_W,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADRS_W-1:0] wr_adrs,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

   load_state_t       state;
   logic [ADRS_W-1:0] count;
   logic [ADRS_W-1:0] adrs;
   logic              cnt_msb;
   logic [3:0]        hi;
   logic [7:0]        csum;
   logic [TMO_W-1:0]  tmo;
   logic              xfer;
   logic              bad_byte;
   logic              timeout;
   logic              fail;

   // Every malformed byte and the idle timeout funnel into one abort path.
   always_comb begin
      in_ready = state inside {HDR, CNT_HI, CNT_LO, W_HI, W_LO, CHK};
      xfer     = in_valid & in_ready;
      timeout  = in_ready & ~xfer & (tmo == TMO_W'(TIMEOUT_CYC - 1));
      bad_byte = 1'b0;
      if (xfer) begin
         case (state)
            HDR:     bad_byte = (in_byte != LOAD_HDR);
            CNT_HI:  bad_byte = |in_byte[7:1];
            W_HI:    bad_byte = |in_byte[7:4];
            CHK:     bad_byte = (in_byte != csum);
            default: bad_byte = 1'b0;
         endcase
      end
      fail = bad_byte | timeout;
   end

   assign cpu_hold = busy;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         wr_en   <= 1'b0;
         wr_adrs <= '0;
         wr_data <= '0;
         count   <= '0;
         adrs    <= '0;
         cnt_msb <= 1'b0;
         hi      <= '0;
         csum    <= '0;
         tmo     <= '0;
      end else begin
         wr_en <= 1'b0;
         if (in_ready) tmo <= xfer ? '0 : tmo + 1'b1;

         if (fail) begin
            state <= ERR;
            err   <= 1'b1;
            busy  <= 1'b0;
         end else begin
            case (state)
               // DONE/ERR behave like IDLE so a start right after completion is honoured.
               IDLE, DONE, ERR: begin
                  state <= IDLE;
                  if (start) begin
                     state <= HDR;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                     err   <= 1'b0;
                     adrs  <= '0;
                     csum  <= '0;
                     tmo   <= '0;
                  end
               end
               HDR:    if (xfer) state <= CNT_HI;
               CNT_HI: if (xfer) begin
                  cnt_msb <= in_byte[0];
                  state   <= CNT_LO;
               end
               CNT_LO: if (xfer) begin
                  count <= ADRS_W'({cnt_msb, in_byte});
                  state <= W_HI;
               end
               W_HI: if (xfer) begin
                  hi    <= in_byte[3:0];
                  csum  <= csum ^ in_byte;
                  state <= W_LO;
               end
               W_LO: if (xfer) begin
                  csum    <= csum ^ in_byte;
                  wr_en   <= 1'b1;
                  wr_adrs <= adrs;
                  wr_data <= DATA_W'({hi, in_byte});
                  if (adrs == count) begin
                     state <= CHK;
                  end else begin
                     adrs  <= adrs + 1'b1;
                     state <= W_HI;
                  end
               end
               CHK: if (xfer) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
